// File: rtl/gate_stim_checker_if.sv
// Bus between the stimulus checker and the 3-gate block.
// The checker drives m,n,u,v and samples the gate results x,y,z.
// The master side is the checker and the slave side is the gate block.
interface gate_stim_checker_if;
  logic m;
  logic n;
  logic u;
  logic v;
  logic x;
  logic y;
  logic z;

  modport master (
    output m, n, u, v,
    input  x, y, z
  );

  modport slave (
    input  m, n, u, v,
    output x, y, z
  );
endinterface

// File: rtl/gate_stim_checker.sv
// gate_stim_checker: on-board self-test driver/checker for the 3-gate block.
// The gate block computes x = m&n, y = m|u and z = m^v.
// The checker sweeps all 16 {m,n,u,v} vectors and samples x,y,z after each
// vector has settled. It counts the vectors whose results mismatch, and
// reports done/pass at the end of the sweep.
// Optional feature: define GATE_CHK_FIRST_FAIL_EN to add the fail_valid,
// fail_vec and fail_xyz outputs. These capture the first mismatching vector
// of each sweep.
module gate_stim_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  gate_stim_checker_if.master gate,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_cnt
`ifdef GATE_CHK_FIRST_FAIL_EN
  ,
  output logic                fail_valid,
  output logic [3:0]          fail_vec,
  output logic [2:0]          fail_xyz
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // The settle counter runs 0..SETTLE_CYCLES-1. A width of 1 is kept even
  // when the settle phase is skipped, so the counter type stays legal.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // The error counter sticks at its maximum instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (c == ERR_MAX) ? c : c + 1'b1;
  endfunction

  // Reference gate results for one stimulus vector {m,n,u,v}.
  function automatic logic [2:0] expect_xyz(input logic [3:0] vec);
    return {vec[3] & vec[2], vec[3] | vec[1], vec[3] ^ vec[0]};
  endfunction

  logic [2:0]       state_q, state_d;
  logic [3:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [2:0]       sampled;
  logic             mismatch;
  logic [ERR_W-1:0] err_inc;

`ifdef GATE_CHK_FIRST_FAIL_EN
  logic             fail_valid_q, fail_valid_d;
  logic [3:0]       fail_vec_q, fail_vec_d;
  logic [2:0]       fail_xyz_q, fail_xyz_d;
`endif

  assign sampled  = {gate.x, gate.y, gate.z};
  assign mismatch = (sampled != expect_xyz(vec_q));
  // A vector adds at most one error, however many of its bits differ.
  assign err_inc  = mismatch ? sat_inc(err_q) : err_q;

  // Next-state logic for the sweep FSM and all registered outputs.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
`ifdef GATE_CHK_FIRST_FAIL_EN
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    fail_xyz_d   = fail_xyz_q;
`endif
    case (state_q)
      S_IDLE: begin
        stim_d = 4'd0;
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = 4'd0;
          err_d   = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef GATE_CHK_FIRST_FAIL_EN
          fail_valid_d = 1'b0;
          fail_vec_d   = 4'd0;
          fail_xyz_d   = 3'd0;
`endif
        end
      end
      S_DRIVE: begin
        if (SETTLE_CYCLES == 0) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        err_d = err_inc;
`ifdef GATE_CHK_FIRST_FAIL_EN
        if (mismatch && !fail_valid_q) begin
          fail_valid_d = 1'b1;
          fail_vec_d   = vec_q;
          fail_xyz_d   = sampled;
        end
`endif
        if (vec_q == 4'hF) begin
          // The last vector's result is already folded into pass here.
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_inc == '0);
          stim_d  = 4'd0;
        end else begin
          state_d = S_DRIVE;
          vec_d   = vec_q + 4'd1;
          stim_d  = vec_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        stim_d  = 4'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 4'd0;
      cnt_q   <= '0;
      stim_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
`ifdef GATE_CHK_FIRST_FAIL_EN
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 4'd0;
      fail_xyz_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
`ifdef GATE_CHK_FIRST_FAIL_EN
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      fail_xyz_q   <= fail_xyz_d;
`endif
    end
  end

  assign gate.m  = stim_q[3];
  assign gate.n  = stim_q[2];
  assign gate.u  = stim_q[1];
  assign gate.v  = stim_q[0];
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;
`ifdef GATE_CHK_FIRST_FAIL_EN
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
  assign fail_xyz   = fail_xyz_q;
`endif

endmodule

// File: tb/tb_gate_stim_checker.sv
// Testbench for gate_stim_checker.
// dut_a uses the default settle time and can be attached to a faulty gate
// model. dut_b uses SETTLE_CYCLES=0 and is run with start held high.
`timescale 1ns/1ps
module tb_gate_stim_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    int         lat;
    logic       pass;
    int         err;
    logic [3:0] fvec;
    logic [2:0] fxyz;
  } sweep_t;

  sweep_t     q_sw_a[$];
  sweep_t     q_sw_b[$];
  logic [3:0] q_vec_a[$];
  int         q_busy_b[$];
  int         t0_a = 0;
  int         t0_b = 0;

  // ---------------- DUT A: default parameters, selectable gate fault
  gate_stim_checker_if ifa();
  logic       rst_n_a = 1'b0;
  logic       start_a = 1'b0;
  logic       busy_a, done_a, pass_a;
  logic [4:0] err_a;
  int         mode_a = 0;   // 0 golden, 1 x stuck at 0, 2 z inverted
`ifdef GATE_CHK_FIRST_FAIL_EN
  logic       fv_a;
  logic [3:0] fvec_a;
  logic [2:0] fxyz_a;
`endif

  assign ifa.x = (mode_a == 1) ? 1'b0 : (ifa.m & ifa.n);
  assign ifa.y = ifa.m | ifa.u;
  assign ifa.z = (mode_a == 2) ? ~(ifa.m ^ ifa.v) : (ifa.m ^ ifa.v);

  gate_stim_checker #(.SETTLE_CYCLES(2), .ERR_W(5)) dut_a (
    .clk     (clk),
    .rst_n   (rst_n_a),
    .start   (start_a),
    .gate    (ifa),
    .busy    (busy_a),
    .done    (done_a),
    .pass    (pass_a),
    .err_cnt (err_a)
`ifdef GATE_CHK_FIRST_FAIL_EN
    ,
    .fail_valid (fv_a),
    .fail_vec   (fvec_a),
    .fail_xyz   (fxyz_a)
`endif
  );

  // ---------------- DUT B: SETTLE_CYCLES=0, golden gate model
  gate_stim_checker_if ifb();
  logic       rst_n_b = 1'b0;
  logic       start_b = 1'b0;
  logic       busy_b, done_b, pass_b;
  logic [4:0] err_b;
`ifdef GATE_CHK_FIRST_FAIL_EN
  logic       fv_b;
  logic [3:0] fvec_b;
  logic [2:0] fxyz_b;
`endif

  assign ifb.x = ifb.m & ifb.n;
  assign ifb.y = ifb.m | ifb.u;
  assign ifb.z = ifb.m ^ ifb.v;

  gate_stim_checker #(.SETTLE_CYCLES(0), .ERR_W(5)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n_b),
    .start   (start_b),
    .gate    (ifb),
    .busy    (busy_b),
    .done    (done_b),
    .pass    (pass_b),
    .err_cnt (err_b)
`ifdef GATE_CHK_FIRST_FAIL_EN
    ,
    .fail_valid (fv_b),
    .fail_vec   (fvec_b),
    .fail_xyz   (fxyz_b)
`endif
  );

  // Expected sweep outcome for a given gate fault.
  function automatic sweep_t model_sweep(input int mode, input int lat);
    sweep_t s;
    s.lat  = lat;
    s.err  = 0;
    s.fvec = 4'd0;
    s.fxyz = 3'd0;
    for (int k = 0; k < 16; k++) begin
      logic [3:0] vec;
      logic [2:0] gold;
      logic [2:0] got;
      vec  = k[3:0];
      gold = {vec[3] & vec[2], vec[3] | vec[1], vec[3] ^ vec[0]};
      got  = gold;
      if (mode == 1) got[2] = 1'b0;
      if (mode == 2) got[0] = ~got[0];
      if (got != gold) begin
        if (s.err == 0) begin
          s.fvec = vec;
          s.fxyz = got;
        end
        s.err++;
      end
    end
    if (s.err > 31) s.err = 31;
    s.pass = (s.err == 0);
    return s;
  endfunction

  // Monitor A: stimulus order and end-of-sweep results.
  logic       busy_a_prev = 1'b0;
  logic [3:0] mnuv_a_prev = 4'd0;
  always @(negedge clk) begin
    logic [3:0] mnuv;
    logic [3:0] ev;
    sweep_t     s;
    mnuv = {ifa.m, ifa.n, ifa.u, ifa.v};
    if (busy_a === 1'b1 && (!busy_a_prev || mnuv != mnuv_a_prev)) begin
      check_eq("a_vec_expected", q_vec_a.size() != 0, 1);
      if (q_vec_a.size() != 0) begin
        ev = q_vec_a.pop_front();
        check_eq("a_vec_order", mnuv, ev);
      end
    end
    if (done_a === 1'b1) begin
      check_eq("a_done_expected", q_sw_a.size() != 0, 1);
      if (q_sw_a.size() != 0) begin
        s = q_sw_a.pop_front();
        check_eq("a_done_latency", cyc - t0_a, s.lat);
        check_eq("a_pass", pass_a, s.pass);
        check_eq("a_err_cnt", err_a, s.err);
        check_eq("a_busy_at_done", busy_a, 0);
        check_eq("a_stim_at_done", mnuv, 0);
`ifdef GATE_CHK_FIRST_FAIL_EN
        check_eq("a_fail_valid", fv_a, s.err != 0);
        if (s.err != 0) begin
          check_eq("a_fail_vec", fvec_a, s.fvec);
          check_eq("a_fail_xyz", fxyz_a, s.fxyz);
        end
`endif
      end
    end
    busy_a_prev <= (busy_a === 1'b1);
    mnuv_a_prev <= mnuv;
  end

  // Monitor B: sweep start times and end-of-sweep results.
  logic busy_b_prev = 1'b0;
  always @(negedge clk) begin
    int     eb;
    sweep_t s;
    if (busy_b === 1'b1 && !busy_b_prev) begin
      check_eq("b_busy_expected", q_busy_b.size() != 0, 1);
      if (q_busy_b.size() != 0) begin
        eb = q_busy_b.pop_front();
        check_eq("b_busy_rise", cyc - t0_b, eb);
      end
    end
    if (done_b === 1'b1) begin
      check_eq("b_done_expected", q_sw_b.size() != 0, 1);
      if (q_sw_b.size() != 0) begin
        s = q_sw_b.pop_front();
        check_eq("b_done_latency", cyc - t0_b, s.lat);
        check_eq("b_pass", pass_b, s.pass);
        check_eq("b_err_cnt", err_b, s.err);
      end
    end
    busy_b_prev <= (busy_b === 1'b1);
  end

  // Queue expectations for one sweep of A and pulse start for one cycle.
  task automatic run_a(input int mode);
    mode_a = mode;
    @(posedge clk); #1;
    q_sw_a.push_back(model_sweep(mode, 65));
    for (int k = 0; k < 16; k++) q_vec_a.push_back(4'(k));
    t0_a    = cyc;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic wait_sweep_a(input int budget);
    int k = 0;
    while (q_sw_a.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("a_sweep_complete", q_sw_a.size(), 0);
    check_eq("a_all_vectors_seen", q_vec_a.size(), 0);
    q_sw_a.delete();
    q_vec_a.delete();
  endtask

  task automatic reset_check_a(input string tag);
    @(posedge clk); #1;
    rst_n_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n_a = 1'b1;
    @(negedge clk);
    check_eq({tag, "_mnuv"}, {ifa.m, ifa.n, ifa.u, ifa.v}, 0);
    check_eq({tag, "_busy"}, busy_a, 0);
    check_eq({tag, "_done"}, done_a, 0);
    check_eq({tag, "_pass"}, pass_a, 0);
    check_eq({tag, "_err"}, err_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    repeat (3) @(posedge clk);

    // Golden sweep, then pass must hold while idle.
    run_a(0);
    wait_sweep_a(100);
    repeat (5) @(negedge clk);
    check_eq("a_pass_held", pass_a, 1);

    // A mid-idle reset clears the pass flag left by the last sweep.
    reset_check_a("rst_after_pass");

    // x stuck at 0, then z inverted.
    run_a(1);
    wait_sweep_a(100);
    run_a(2);
    wait_sweep_a(100);
    reset_check_a("rst_after_err");

    // A start pulse while busy is ignored.
    run_a(0);
    repeat (9) @(posedge clk);
    #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_sweep_a(100);

    // Reset at cycle 20 aborts the sweep.
    run_a(0);
    repeat (19) @(posedge clk);
    #1;
    rst_n_a = 1'b0;
    @(posedge clk); #1;
    rst_n_a = 1'b1;
    q_sw_a.delete();
    q_vec_a.delete();
    @(negedge clk);
    check_eq("abort_busy", busy_a, 0);
    check_eq("abort_mnuv", {ifa.m, ifa.n, ifa.u, ifa.v}, 0);
    check_eq("abort_err", err_a, 0);
    check_eq("abort_done", done_a, 0);
    repeat (3) @(negedge clk);
    check_eq("abort_stays_idle", busy_a, 0);
    run_a(0);
    wait_sweep_a(100);

    // DUT B: no settle phase, start held high across two sweeps.
    @(posedge clk); #1;
    q_sw_b.push_back(model_sweep(0, 33));
    q_sw_b.push_back(model_sweep(0, 67));
    q_busy_b.push_back(1);
    q_busy_b.push_back(35);
    t0_b    = cyc;
    start_b = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    start_b = 1'b0;
    for (int k = 0; k < 100 && q_sw_b.size() != 0; k++) @(negedge clk);
    check_eq("b_sweeps_complete", q_sw_b.size(), 0);
    check_eq("b_busy_rises_seen", q_busy_b.size(), 0);
    repeat (5) @(negedge clk);
    check_eq("b_idle_after", busy_b, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
